// File: rtl/commit_unit.sv
// commit_unit: commit-side consumer of the ALU/LS/MULT pipeline outputs.
//
// Round-robin picks at most one valid pipeline result per cycle. Clean results
// drive the single register-file write port and release scoreboard
// reservations one cycle later. Erroring results become a trap request plus a
// one-cycle flush. The unit then accepts nothing until the CSR block acks.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   pl_valid_i         per-pipeline result valid
//   pl_output_i        per-pipeline result payload (pl_out_t)
//   ds_rdy_o           per-pipeline ready, one-hot on the winner (combinational)
//   rf_we_o/_waddr_o/_wdata_o/_wcap_o   register-file write port (registered)
//   rsv_clr_o          one-hot scoreboard release; bit 0 never set
//   trap_valid_o/_pc_o/_mcause_o/_mtval_o   trap request to the CSR block
//   trap_ack_i         CSR block has taken the trap
//   flush_o            one-cycle flush pulse to every pipeline
//   commit_cnt_o       retired-result counter

package commit_unit_pkg;
    localparam int unsigned OpW     = 65;
    localparam int unsigned McauseW = 6;

    typedef struct packed {
        logic               we;
        logic               wrsv;
        logic [4:0]         waddr;
        logic [OpW-1:0]     wdata;
        logic               err;
        logic [31:0]        pc;
        logic [McauseW-1:0] mcause;
        logic [31:0]        mtval;
        logic               is_cap;
    } pl_out_t;
endpackage

module commit_unit
    import commit_unit_pkg::*;
#(
    parameter int unsigned NumPl     = 3,
    parameter bit          CHERIoTEn = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NumPl-1:0]         pl_valid_i,
    input  pl_out_t [NumPl-1:0]      pl_output_i,
    output logic [NumPl-1:0]         ds_rdy_o,
    output logic                     rf_we_o,
    output logic [4:0]               rf_waddr_o,
    output logic [OpW-1:0]           rf_wdata_o,
    output logic                     rf_wcap_o,
    output logic [31:0]              rsv_clr_o,
    output logic                     trap_valid_o,
    output logic [31:0]              trap_pc_o,
    output logic [McauseW-1:0]       trap_mcause_o,
    output logic [31:0]              trap_mtval_o,
    input  logic                     trap_ack_i,
    output logic                     flush_o,
    output logic [31:0]              commit_cnt_o
);

    localparam int unsigned PtrW = $clog2(NumPl);

    // Without CHERIoT only the 32-bit integer part is architecturally visible.
    localparam logic [OpW-1:0] WdataMask =
        CHERIoTEn ? {OpW{1'b1}} : {{(OpW-32){1'b0}}, {32{1'b1}}};

    typedef enum logic [1:0] {StRun, StFlush, StWaitAck} state_e;

    state_e              state_q, state_d;
    logic [PtrW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [31:0]         commit_cnt_q, commit_cnt_d;
    logic                rf_we_q, rf_we_d;
    logic [4:0]          rf_waddr_q, rf_waddr_d;
    logic [OpW-1:0]      rf_wdata_q, rf_wdata_d;
    logic                rf_wcap_q, rf_wcap_d;
    logic [31:0]         rsv_clr_q, rsv_clr_d;
    logic                trap_valid_q, trap_valid_d;
    logic [31:0]         trap_pc_q, trap_pc_d;
    logic [McauseW-1:0]  trap_mcause_q, trap_mcause_d;
    logic [31:0]         trap_mtval_q, trap_mtval_d;
    logic                flush_q, flush_d;

    logic                grant_valid;
    logic [PtrW-1:0]     grant_idx;
    int unsigned         cand_idx;
    logic                xfer;
    pl_out_t             sel;

    // Cyclic search for the first valid pipeline at or after rr_ptr_q.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand_idx    = 0;
        for (int unsigned i = 0; i < NumPl; i++) begin
            cand_idx = (32'(rr_ptr_q) + i) % NumPl;
            if (!grant_valid && pl_valid_i[cand_idx[PtrW-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand_idx[PtrW-1:0];
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NumPl; i++) begin
            ds_rdy_o[i] = (state_q == StRun) && grant_valid && (grant_idx == PtrW'(i));
        end
    end

    assign xfer = (state_q == StRun) && grant_valid;
    assign sel  = pl_output_i[grant_idx];

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        commit_cnt_d  = commit_cnt_q;
        rf_we_d       = 1'b0;
        rf_waddr_d    = rf_waddr_q;
        rf_wdata_d    = rf_wdata_q;
        rf_wcap_d     = rf_wcap_q;
        rsv_clr_d     = '0;
        trap_valid_d  = trap_valid_q;
        trap_pc_d     = trap_pc_q;
        trap_mcause_d = trap_mcause_q;
        trap_mtval_d  = trap_mtval_q;
        flush_d       = 1'b0;

        unique case (state_q)
            StRun: begin
                if (xfer) begin
                    rr_ptr_d = (grant_idx == PtrW'(NumPl - 1)) ? '0 : grant_idx + 1'b1;
                    if (sel.err) begin
                        state_d       = StFlush;
                        trap_valid_d  = 1'b1;
                        trap_pc_d     = sel.pc;
                        trap_mcause_d = sel.mcause;
                        trap_mtval_d  = sel.mtval;
                        flush_d       = 1'b1;
                    end else begin
                        rf_we_d      = sel.we && (sel.waddr != 5'd0);
                        rf_waddr_d   = sel.waddr;
                        rf_wdata_d   = sel.wdata & WdataMask;
                        rf_wcap_d    = sel.is_cap && sel.we;
                        // wrsv=0 marks a WAW-cancelled result: write, but the
                        // reservation belongs to a younger instruction.
                        if (sel.we && sel.wrsv && (sel.waddr != 5'd0)) begin
                            rsv_clr_d[sel.waddr] = 1'b1;
                        end
                        commit_cnt_d = commit_cnt_q + 32'd1;
                    end
                end
            end
            StFlush: begin
                if (trap_ack_i) begin
                    state_d      = StRun;
                    trap_valid_d = 1'b0;
                end else begin
                    state_d = StWaitAck;
                end
            end
            StWaitAck: begin
                if (trap_ack_i) begin
                    state_d      = StRun;
                    trap_valid_d = 1'b0;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StRun;
            rr_ptr_q      <= '0;
            commit_cnt_q  <= '0;
            rf_we_q       <= 1'b0;
            rf_waddr_q    <= '0;
            rf_wdata_q    <= '0;
            rf_wcap_q     <= 1'b0;
            rsv_clr_q     <= '0;
            trap_valid_q  <= 1'b0;
            trap_pc_q     <= '0;
            trap_mcause_q <= '0;
            trap_mtval_q  <= '0;
            flush_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            commit_cnt_q  <= commit_cnt_d;
            rf_we_q       <= rf_we_d;
            rf_waddr_q    <= rf_waddr_d;
            rf_wdata_q    <= rf_wdata_d;
            rf_wcap_q     <= rf_wcap_d;
            rsv_clr_q     <= rsv_clr_d;
            trap_valid_q  <= trap_valid_d;
            trap_pc_q     <= trap_pc_d;
            trap_mcause_q <= trap_mcause_d;
            trap_mtval_q  <= trap_mtval_d;
            flush_q       <= flush_d;
        end
    end

    assign rf_we_o       = rf_we_q;
    assign rf_waddr_o    = rf_waddr_q;
    assign rf_wdata_o    = rf_wdata_q;
    assign rf_wcap_o     = rf_wcap_q;
    assign rsv_clr_o     = rsv_clr_q;
    assign trap_valid_o  = trap_valid_q;
    assign trap_pc_o     = trap_pc_q;
    assign trap_mcause_o = trap_mcause_q;
    assign trap_mtval_o  = trap_mtval_q;
    assign flush_o       = flush_q;
    assign commit_cnt_o  = commit_cnt_q;

endmodule
